// File: rtl/sdram_burst_sequencer.sv
// sdram_burst_sequencer
// Round-robin burst sequencer between NUM_CH client FIFO pairs and a single
// full-page SDRAM controller. Each accepted command issues one controller
// request per burst, advances the {row, bank} burst address after every burst
// and steers data beats between the controller and the owning channel's FIFOs.
// Optional build macro: SDRAM_SEQ_PERF_EN adds perf_clr, perf_beats and
// perf_busy (saturating performance counters).

module sdram_burst_sequencer #(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 15,
   parameter int BURST_LEN = 512,
   parameter int NB_W      = 8
) (
   input  logic                       sram_clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          req_valid,
   output logic [NUM_CH-1:0]          req_ready,
   input  logic [NUM_CH-1:0]          req_rw,
   input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CH*NB_W-1:0]     req_nbursts,
   output logic [NUM_CH-1:0]          done,
   input  logic [NUM_CH*DATA_W-1:0]   wf_data,
   output logic [NUM_CH-1:0]          wf_rd_en,
   output logic [DATA_W-1:0]          rf_data,
   output logic [NUM_CH-1:0]          rf_wr_en,
   output logic                       busy,
   output logic                       overrun,
   output logic                       ctrl_rw,
   output logic                       ctrl_rw_en,
   output logic [ADDR_W-1:0]          ctrl_addr,
   output logic [DATA_W-1:0]          ctrl_f2s_data,
   input  logic                       ctrl_ready,
   input  logic                       ctrl_f2s_valid,
   input  logic                       ctrl_s2f_valid,
   input  logic [DATA_W-1:0]          ctrl_s2f_data
`ifdef SDRAM_SEQ_PERF_EN
   ,
   input  logic                       perf_clr,
   output logic [31:0]                perf_beats,
   output logic [31:0]                perf_busy
`endif
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BC_W = $clog2(BURST_LEN + 1);
   localparam logic [BC_W-1:0] BEAT_MAX = BC_W'(BURST_LEN);
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] BURST = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]        state;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   cur_ch;
   logic              cur_rw;
   logic [ADDR_W-1:0] cur_addr;
   logic [NB_W-1:0]   remaining;
   logic [BC_W-1:0]   beat_cnt;

   logic              grant_found;
   logic [CH_W-1:0]   grant_ch;
   logic              sel_rw;
   logic [ADDR_W-1:0] sel_addr;
   logic [NB_W-1:0]   sel_nb;

   logic              beat_valid;
   logic              at_max;
   logic              fwd;

   // Round-robin search: first requesting channel at or after rr_ptr, with wrap
   always_comb begin
      logic [CH_W-1:0] idx;
      grant_found = 1'b0;
      grant_ch    = '0;
      idx         = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_ch    = idx;
         end
      end
   end

   // Command fields of the channel currently winning arbitration
   always_comb begin
      sel_rw   = req_rw[grant_ch];
      sel_addr = req_addr[int'(grant_ch)*ADDR_W +: ADDR_W];
      sel_nb   = req_nbursts[int'(grant_ch)*NB_W +: NB_W];
   end

   // Beat qualification: the valid that matters depends on the latched direction
   always_comb begin
      beat_valid = cur_rw ? ctrl_s2f_valid : ctrl_f2s_valid;
      at_max     = (beat_cnt == BEAT_MAX);
      fwd        = (state == BURST) && beat_valid && !at_max;
   end

   // Sequencer state, latched command and burst bookkeeping
   always_ff @(posedge sram_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_ch    <= '0;
         cur_rw    <= 1'b0;
         cur_addr  <= '0;
         remaining <= '0;
         beat_cnt  <= '0;
         overrun   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_found) begin
                  cur_ch    <= grant_ch;
                  cur_rw    <= sel_rw;
                  cur_addr  <= sel_addr;
                  remaining <= sel_nb;
                  rr_ptr    <= (grant_ch == LAST_CH) ? '0 : grant_ch + CH_W'(1);
                  state     <= (sel_nb == '0) ? DONE : ISSUE;
               end
            end
            ISSUE: begin
               if (ctrl_ready) begin
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (beat_valid) begin
                  if (at_max) begin
                     overrun <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + BC_W'(1);
                  end
               end else if (at_max) begin
                  remaining <= remaining - NB_W'(1);
                  cur_addr  <= cur_addr + ADDR_W'(1);
                  state     <= (remaining == NB_W'(1)) ? DONE : ISSUE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Accept handshake is only offered in IDLE, one-hot to the granted channel
   always_comb begin
      req_ready = '0;
      if (rst_n && (state == IDLE) && grant_found) begin
         req_ready[grant_ch] = 1'b1;
      end
   end

   // Per-channel strobes: FIFO pop/push for forwarded beats, completion pulse
   always_comb begin
      wf_rd_en = '0;
      rf_wr_en = '0;
      done     = '0;
      if (fwd) begin
         if (cur_rw) begin
            rf_wr_en[cur_ch] = 1'b1;
         end else begin
            wf_rd_en[cur_ch] = 1'b1;
         end
      end
      if (state == DONE) begin
         done[cur_ch] = 1'b1;
      end
   end

   // Controller request and data steering for the owning channel
   always_comb begin
      ctrl_rw       = cur_rw;
      ctrl_addr     = cur_addr;
      ctrl_rw_en    = (state == ISSUE) && ctrl_ready;
      busy          = (state != IDLE);
      ctrl_f2s_data = ((state == BURST) && !cur_rw) ?
                      wf_data[int'(cur_ch)*DATA_W +: DATA_W] : '0;
      rf_data       = ((state == BURST) && cur_rw) ? ctrl_s2f_data : '0;
   end

`ifdef SDRAM_SEQ_PERF_EN
   // Saturating counters of forwarded words and non-IDLE cycles
   always_ff @(posedge sram_clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_beats <= '0;
         perf_busy  <= '0;
      end else if (perf_clr) begin
         perf_beats <= '0;
         perf_busy  <= '0;
      end else begin
         if (fwd && (perf_beats != '1)) begin
            perf_beats <= perf_beats + 32'd1;
         end
         if ((state != IDLE) && (perf_busy != '1)) begin
            perf_busy <= perf_busy + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// tb_sdram_burst_sequencer
// Directed bench for sdram_burst_sequencer with NUM_CH=2, BURST_LEN=8.
// The bench plays the SDRAM controller and the client FIFOs; expected values
// are hand-derived constants.

module tb_sdram_burst_sequencer;

   localparam int NUM_CH    = 2;
   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 15;
   localparam int BURST_LEN = 8;
   localparam int NB_W      = 8;

   logic                     sram_clk = 1'b0;
   logic                     rst_n;
   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH-1:0]        req_ready;
   logic [NUM_CH-1:0]        req_rw;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*NB_W-1:0]   req_nbursts;
   logic [NUM_CH-1:0]        done;
   logic [NUM_CH*DATA_W-1:0] wf_data;
   logic [NUM_CH-1:0]        wf_rd_en;
   logic [DATA_W-1:0]        rf_data;
   logic [NUM_CH-1:0]        rf_wr_en;
   logic                     busy;
   logic                     overrun;
   logic                     ctrl_rw;
   logic                     ctrl_rw_en;
   logic [ADDR_W-1:0]        ctrl_addr;
   logic [DATA_W-1:0]        ctrl_f2s_data;
   logic                     ctrl_ready;
   logic                     ctrl_f2s_valid;
   logic                     ctrl_s2f_valid;
   logic [DATA_W-1:0]        ctrl_s2f_data;

   int checks = 0;
   int errors = 0;

   int n_rwen  = 0;
   int n_pop0  = 0;
   int n_pop1  = 0;
   int n_push0 = 0;
   int n_push1 = 0;
   int n_done0 = 0;
   int n_done1 = 0;
   logic [ADDR_W-1:0] addr_log [64];

   sdram_burst_sequencer #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .BURST_LEN(BURST_LEN), .NB_W(NB_W)
   ) dut (
      .sram_clk(sram_clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_nbursts(req_nbursts), .done(done),
      .wf_data(wf_data), .wf_rd_en(wf_rd_en), .rf_data(rf_data),
      .rf_wr_en(rf_wr_en), .busy(busy), .overrun(overrun),
      .ctrl_rw(ctrl_rw), .ctrl_rw_en(ctrl_rw_en), .ctrl_addr(ctrl_addr),
      .ctrl_f2s_data(ctrl_f2s_data), .ctrl_ready(ctrl_ready),
      .ctrl_f2s_valid(ctrl_f2s_valid), .ctrl_s2f_valid(ctrl_s2f_valid),
      .ctrl_s2f_data(ctrl_s2f_data)
   );

   // Free-running clock
   always #5 sram_clk = ~sram_clk;

   // Event counters sampled on the falling edge, away from the active edge
   always @(negedge sram_clk) begin
      if (ctrl_rw_en) begin
         addr_log[n_rwen % 64] <= ctrl_addr;
         n_rwen <= n_rwen + 1;
      end
      n_pop0  <= n_pop0  + int'(wf_rd_en[0]);
      n_pop1  <= n_pop1  + int'(wf_rd_en[1]);
      n_push0 <= n_push0 + int'(rf_wr_en[0]);
      n_push1 <= n_push1 + int'(rf_wr_en[1]);
      n_done0 <= n_done0 + int'(done[0]);
      n_done1 <= n_done1 + int'(done[1]);
   end

   // Post a command on one channel and check the combinational accept
   task automatic accept(input int ch, input logic rw, input logic [ADDR_W-1:0] addr,
                         input logic [NB_W-1:0] nb, input logic [1:0] exp_ready,
                         input string nm);
      req_rw[ch] = rw;
      req_addr[ch*ADDR_W +: ADDR_W] = addr;
      req_nbursts[ch*NB_W +: NB_W] = nb;
      req_valid[ch] = 1'b1;
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
         errors++;
         $display("[TB] FAIL %s req_ready: got %b expected %b", nm, req_ready, exp_ready);
      end
      @(posedge sram_clk); #1;
      req_valid[ch] = 1'b0;
   endtask

   // Act as the controller: raise ready and expect one request with this address
   task automatic issue_burst(input logic [ADDR_W-1:0] exp_addr, input logic exp_rw,
                              input string nm);
      bit got;
      got = 1'b0;
      ctrl_ready = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         #1;
         if (ctrl_rw_en === 1'b1) begin
            got = 1'b1;
         end else begin
            @(posedge sram_clk); #1;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("[TB] FAIL %s ctrl_rw_en: got 0 expected 1 within 20 cycles", nm);
      end else begin
         checks++;
         if (ctrl_addr !== exp_addr || ctrl_rw !== exp_rw) begin
            errors++;
            $display("[TB] FAIL %s ctrl_addr/ctrl_rw: got %h/%b expected %h/%b",
                     nm, ctrl_addr, ctrl_rw, exp_addr, exp_rw);
         end
         @(posedge sram_clk); #1;
      end
      ctrl_ready = 1'b0;
   endtask

   // Drive n controller beats; the first n_fwd must reach the channel's FIFO
   task automatic beats(input int ch, input logic rd, input int n, input int n_fwd,
                        input string nm);
      logic [1:0]        oh;
      logic [1:0]        exp_en;
      logic [DATA_W-1:0] exp_d;
      oh = 2'b01 << ch;
      for (int i = 0; i < n; i++) begin
         exp_en = (i < n_fwd) ? oh : 2'b00;
         if (rd) begin
            exp_d = 16'hA000 + 16'(i);
            ctrl_s2f_valid = 1'b1;
            ctrl_s2f_data  = exp_d;
         end else begin
            exp_d = 16'(ch*256 + i);
            ctrl_f2s_valid = 1'b1;
            wf_data[ch*DATA_W +: DATA_W] = exp_d;
         end
         #1;
         checks++;
         if (rd) begin
            if (rf_wr_en !== exp_en || (i < n_fwd && rf_data !== exp_d)) begin
               errors++;
               $display("[TB] FAIL %s beat %0d rf_wr_en/rf_data: got %b/%h expected %b/%h",
                        nm, i, rf_wr_en, rf_data, exp_en, exp_d);
            end
         end else begin
            if (wf_rd_en !== exp_en || (i < n_fwd && ctrl_f2s_data !== exp_d)) begin
               errors++;
               $display("[TB] FAIL %s beat %0d wf_rd_en/ctrl_f2s_data: got %b/%h expected %b/%h",
                        nm, i, wf_rd_en, ctrl_f2s_data, exp_en, exp_d);
            end
         end
         @(posedge sram_clk); #1;
      end
      ctrl_s2f_valid = 1'b0;
      ctrl_f2s_valid = 1'b0;
   endtask

   // Wait (bounded) for the completion pulse and check which channel it names
   task automatic wait_done(input logic [1:0] exp, input string nm);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
         #1;
         if (done !== 2'b00) begin
            seen = 1'b1;
            checks++;
            if (done !== exp) begin
               errors++;
               $display("[TB] FAIL %s done: got %b expected %b", nm, done, exp);
            end
         end
         @(posedge sram_clk); #1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s done: got 00 expected %b within 12 cycles", nm, exp);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (busy !== 1'b0 || req_ready !== 2'b00 || done !== 2'b00 || ctrl_rw_en !== 1'b0 ||
          overrun !== 1'b0 || ctrl_addr !== 15'h0 || wf_rd_en !== 2'b00 || rf_wr_en !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset outputs: got busy=%b ready=%b done=%b rw_en=%b ovr=%b addr=%h expected all 0",
                  busy, req_ready, done, ctrl_rw_en, overrun, ctrl_addr);
      end
      @(posedge sram_clk); @(posedge sram_clk); #1;
      rst_n = 1'b1;
      @(posedge sram_clk); #1;
   endtask

   task automatic test_single_write();
      int r0, p0, d0;
      r0 = n_rwen; p0 = n_pop0; d0 = n_done0;
      accept(0, 1'b0, 15'h0010, 8'd1, 2'b01, "single_write");
      req_valid = 2'b10;
      ctrl_f2s_valid = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b1 || req_ready !== 2'b00 || wf_rd_en !== 2'b00) begin
         errors++;
         $display("[TB] FAIL single_write in ISSUE busy/req_ready/wf_rd_en: got %b/%b/%b expected 1/00/00",
                  busy, req_ready, wf_rd_en);
      end
      req_valid = 2'b00;
      ctrl_f2s_valid = 1'b0;
      issue_burst(15'h0010, 1'b0, "single_write");
      beats(0, 1'b0, 8, 8, "single_write");
      wait_done(2'b01, "single_write");
      checks++;
      if (n_rwen - r0 != 1 || n_pop0 - p0 != 8 || n_done0 - d0 != 1) begin
         errors++;
         $display("[TB] FAIL single_write counts rw_en/pops/done: got %0d/%0d/%0d expected 1/8/1",
                  n_rwen - r0, n_pop0 - p0, n_done0 - d0);
      end
   endtask

   task automatic test_multi_burst_wrap();
      int r0, p0, d0;
      r0 = n_rwen; p0 = n_pop0; d0 = n_done0;
      accept(0, 1'b0, 15'h7FFF, 8'd3, 2'b01, "wrap");
      issue_burst(15'h7FFF, 1'b0, "wrap_b0");
      beats(0, 1'b0, 8, 8, "wrap_b0");
      issue_burst(15'h0000, 1'b0, "wrap_b1");
      beats(0, 1'b0, 8, 8, "wrap_b1");
      issue_burst(15'h0001, 1'b0, "wrap_b2");
      beats(0, 1'b0, 8, 8, "wrap_b2");
      wait_done(2'b01, "wrap");
      checks++;
      if (n_rwen - r0 != 3 || n_pop0 - p0 != 24 || n_done0 - d0 != 1) begin
         errors++;
         $display("[TB] FAIL wrap counts rw_en/pops/done: got %0d/%0d/%0d expected 3/24/1",
                  n_rwen - r0, n_pop0 - p0, n_done0 - d0);
      end
      checks++;
      if (addr_log[r0 % 64] !== 15'h7FFF || addr_log[(r0+1) % 64] !== 15'h0000 ||
          addr_log[(r0+2) % 64] !== 15'h0001) begin
         errors++;
         $display("[TB] FAIL wrap address log: got %h %h %h expected 7fff 0000 0001",
                  addr_log[r0 % 64], addr_log[(r0+1) % 64], addr_log[(r0+2) % 64]);
      end
   endtask

   task automatic test_round_robin();
      int q0, q1;
      rst_n = 1'b0;
      @(posedge sram_clk); #1;
      rst_n = 1'b1;
      q0 = n_push0; q1 = n_push1;
      req_rw = 2'b11;
      req_addr = {15'h0200, 15'h0100};
      req_nbursts = {8'd1, 8'd1};
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL rr first grant req_ready: got %b expected 01", req_ready);
      end
      @(posedge sram_clk); #1;
      req_valid = 2'b10;
      issue_burst(15'h0100, 1'b1, "rr_ch0");
      beats(0, 1'b1, 8, 8, "rr_ch0");
      wait_done(2'b01, "rr_ch0");
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("[TB] FAIL rr second grant req_ready: got %b expected 10", req_ready);
      end
      @(posedge sram_clk); #1;
      req_valid = 2'b00;
      issue_burst(15'h0200, 1'b1, "rr_ch1");
      beats(1, 1'b1, 8, 8, "rr_ch1");
      wait_done(2'b10, "rr_ch1");
      checks++;
      if (n_push0 - q0 != 8 || n_push1 - q1 != 8) begin
         errors++;
         $display("[TB] FAIL rr push counts ch0/ch1: got %0d/%0d expected 8/8",
                  n_push0 - q0, n_push1 - q1);
      end
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("[TB] FAIL rr pointer back at 0 req_ready: got %b expected 01", req_ready);
      end
      req_valid = 2'b00;
      @(posedge sram_clk); #1;
   endtask

   task automatic test_zero_length();
      int r0, d1;
      r0 = n_rwen; d1 = n_done1;
      accept(1, 1'b0, 15'h0033, 8'd0, 2'b10, "zero_len");
      wait_done(2'b10, "zero_len");
      @(posedge sram_clk); #1;
      checks++;
      if (n_rwen - r0 != 0 || n_done1 - d1 != 1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL zero_len rw_en/done/busy: got %0d/%0d/%b expected 0/1/0",
                  n_rwen - r0, n_done1 - d1, busy);
      end
   endtask

   task automatic test_overrun();
      int q0;
      q0 = n_push0;
      accept(0, 1'b1, 15'h0040, 8'd1, 2'b01, "overrun");
      issue_burst(15'h0040, 1'b1, "overrun");
      beats(0, 1'b1, 9, 8, "overrun");
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun flag: got %b expected 1", overrun);
      end
      wait_done(2'b01, "overrun");
      @(posedge sram_clk); @(posedge sram_clk); #1;
      checks++;
      if (overrun !== 1'b1 || n_push0 - q0 != 8) begin
         errors++;
         $display("[TB] FAIL overrun sticky/pushes: got %b/%0d expected 1/8", overrun, n_push0 - q0);
      end
   endtask

   task automatic test_reset_mid_burst();
      int d0, d1, p0;
      d0 = n_done0; d1 = n_done1;
      accept(1, 1'b0, 15'h0200, 8'd2, 2'b10, "rst_mid");
      issue_burst(15'h0200, 1'b0, "rst_mid");
      beats(1, 1'b0, 4, 4, "rst_mid");
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || wf_rd_en !== 2'b00 || ctrl_rw_en !== 1'b0 || done !== 2'b00 ||
          ctrl_addr !== 15'h0 || ctrl_f2s_data !== 16'h0 || overrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_mid async outputs: got busy=%b pop=%b rw_en=%b done=%b addr=%h data=%h ovr=%b expected all 0",
                  busy, wf_rd_en, ctrl_rw_en, done, ctrl_addr, ctrl_f2s_data, overrun);
      end
      @(posedge sram_clk); @(posedge sram_clk); #1;
      rst_n = 1'b1;
      checks++;
      if (n_done0 - d0 != 0 || n_done1 - d1 != 0) begin
         errors++;
         $display("[TB] FAIL rst_mid done pulses: got %0d expected 0", (n_done0 - d0) + (n_done1 - d1));
      end
      d0 = n_done0; p0 = n_pop0;
      accept(0, 1'b0, 15'h0123, 8'd1, 2'b01, "rst_mid_after");
      issue_burst(15'h0123, 1'b0, "rst_mid_after");
      beats(0, 1'b0, 8, 8, "rst_mid_after");
      wait_done(2'b01, "rst_mid_after");
      checks++;
      if (n_pop0 - p0 != 8 || n_done0 - d0 != 1) begin
         errors++;
         $display("[TB] FAIL rst_mid_after pops/done: got %0d/%0d expected 8/1", n_pop0 - p0, n_done0 - d0);
      end
   endtask

   // Scenario sequence
   initial begin
      rst_n          = 1'b0;
      req_valid      = '0;
      req_rw         = '0;
      req_addr       = '0;
      req_nbursts    = '0;
      wf_data        = '0;
      ctrl_ready     = 1'b0;
      ctrl_f2s_valid = 1'b0;
      ctrl_s2f_valid = 1'b0;
      ctrl_s2f_data  = '0;
      test_reset();
      test_single_write();
      test_multi_burst_wrap();
      test_round_robin();
      test_zero_length();
      test_overrun();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
